// File: rtl/add_acc_pkg.sv
// add_acc_pkg: shared width and state encoding for the add_accumulator slice
package add_acc_pkg;
  localparam int DATA_W = 32;
  typedef enum logic {ACC, OUT} acc_state_t;
endpackage

// File: rtl/adder.sv
// adder: combinational 32-bit sum path feeding the accumulator
module adder
  import add_acc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/add_accumulator.sv
// add_accumulator: sums LEN accepted operands and emits one held result per group
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int LEN      = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);
  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);
  acc_state_t state, state_nx;
  logic [DATA_W-1:0] acc, sum, acc_nx;
  logic [CW-1:0] cnt;
  logic ovf, carry, live, take, done;
  adder u_adder (.a(acc), .b(in_data), .y(sum));
  // live keeps in_ready low through reset and releases it one edge later
  assign in_ready  = live && state == ACC;
  assign out_valid = state == OUT;
  always_comb begin
    carry    = sum < acc;
    acc_nx   = (SATURATE && carry) ? '1 : sum;
    take     = in_valid && in_ready && !clear;
    done     = take && cnt == LAST;
    state_nx = clear ? ACC : done ? OUT : (state == OUT && out_ready) ? ACC : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      live    <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      live  <= 1'b1;
      state <= state_nx;
      if (clear || done) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (take) begin
        acc <= acc_nx;
        cnt <= cnt + 1'b1;
        ovf <= ovf | carry;
      end
      if (clear) begin
        out_sum <= '0;
        out_ovf <= 1'b0;
      end else if (done) begin
        out_sum <= acc_nx;
        out_ovf <= ovf | carry;
      end
    end
endmodule

// File: tb/tb_add_accumulator.sv
// tb_add_accumulator: table vectors plus scoreboard over four LEN/SATURATE configurations
module tb_add_accumulator;
  localparam int LENS [4] = '{4, 2, 2, 1};
  localparam bit SATS [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] clear = '0, in_valid = '0, in_ready, out_valid, out_ready = '1, out_ovf;
  logic [3:0][31:0] in_data = '0, out_sum;
  logic [32:0] exp_q [4][$];
  logic [31:0] m_acc [4];
  int m_cnt [4];
  logic m_ovf [4];
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] d [4];
    logic [31:0] sum;
    logic        ovf;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    add_accumulator #(.LEN(LENS[g]), .SATURATE(SATS[g])) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_sum(out_sum[g]), .out_ovf(out_ovf[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  always @(negedge clk)
    for (int k = 0; k < 4; k++)
      if (rst_n && out_valid[k] && out_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dut%0d unexpected result: got sum %h ovf %b, required none", k, out_sum[k], out_ovf[k]);
        end else
          chk($sformatf("dut%0d result {ovf,sum}", k), {31'd0, out_ovf[k], out_sum[k]}, {31'd0, exp_q[k].pop_front()});
      end

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_q[k].delete();
      m_acc[k] = '0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // dut0 expectations are pushed as explicit constants; the others use the reference model
  task automatic send(input int k, input logic [31:0] d);
    int t = 0;
    logic [32:0] s;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    while (!in_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[k]) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d accept timeout: in_ready %b, required 1", k, in_ready[k]);
    end else if (k != 0) begin
      s = {1'b0, m_acc[k]} + {1'b0, d};
      m_ovf[k] = m_ovf[k] | s[32];
      m_acc[k] = (SATS[k] && s[32]) ? 32'hFFFF_FFFF : s[31:0];
      m_cnt[k]++;
      if (m_cnt[k] == LENS[k]) begin
        exp_q[k].push_back({m_ovf[k], m_acc[k]});
        m_acc[k] = '0;
        m_cnt[k] = 0;
        m_ovf[k] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k);
    int t = 0;
    while (exp_q[k].size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q[k].size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL dut%0d drain timeout: %0d results outstanding, required 0", k, exp_q[k].size());
    end
  endtask

  task automatic wait_valid(input int k);
    int t = 0;
    while (!out_valid[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("dut%0d out_valid arrives", k), {63'd0, out_valid[k]}, 64'd1);
  endtask

  function automatic logic [31:0] rnd();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{d: '{32'd1, 32'd2, 32'd3, 32'd4}, sum: 32'd10, ovf: 1'b0};
    vecs[1] = '{d: '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0}, sum: 32'd0, ovf: 1'b1};
    vecs[2] = '{d: '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd0}, sum: 32'd5, ovf: 1'b1};
    vecs[3] = '{d: '{32'd0, 32'd0, 32'd0, 32'd0}, sum: 32'd0, ovf: 1'b0};
    vecs[4] = '{d: '{32'h1234_5678, 32'h1111_1111, 32'd0, 32'd1}, sum: 32'h2345_678A, ovf: 1'b0};
    vecs[5] = '{d: '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, sum: 32'hFFFF_FFFC, ovf: 1'b1};
    vecs[6] = '{d: '{32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0}, sum: 32'h8000_0000, ovf: 1'b0};
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset {in_ready,out_valid,out_ovf,out_sum}", {in_ready[0], out_valid[0], out_ovf[0], out_sum[0]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after release", {63'd0, in_ready[0]}, 64'd1);

    for (int i = 0; i < 7; i++) begin
      exp_q[0].push_back({vecs[i].ovf, vecs[i].sum});
      for (int j = 0; j < 4; j++) send(0, vecs[i].d[j]);
    end
    idle(0);
    wait_out(0);

    fork
      begin send(1, 32'hFFFF_FFFF); send(1, 32'd2); for (int i = 0; i < 12; i++) send(1, rnd()); idle(1); end
      begin send(2, 32'hFFFF_FFFF); send(2, 32'd2); for (int i = 0; i < 12; i++) send(2, rnd()); idle(2); end
      begin send(3, 32'd42); send(3, 32'hFFFF_FFFF); for (int i = 0; i < 12; i++) send(3, rnd()); idle(3); end
    join
    for (int k = 1; k < 4; k++) wait_out(k);

    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    exp_q[0].push_back({1'b0, 32'd100});
    send(0, 32'd10); send(0, 32'd20); send(0, 32'd30); send(0, 32'd40);
    idle(0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 32'd999;
      chk("backpressure {in_ready,out_sum}", {31'd0, in_ready[0], out_sum[0]}, {31'd0, 1'b0, 32'd100});
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after accept {in_ready,out_valid}", {62'd0, in_ready[0], out_valid[0]}, 64'd2);
    exp_q[0].push_back({1'b0, 32'd4});
    for (int i = 0; i < 4; i++) send(0, 32'd1);
    idle(0);
    wait_out(0);

    send(0, 32'd5); send(0, 32'd6);
    @(negedge clk);
    clear[0] = 1'b1;
    in_data[0] = 32'd100;
    @(negedge clk);
    clear[0] = 1'b0;
    in_valid[0] = 1'b0;
    exp_q[0].push_back({1'b0, 32'd4});
    for (int i = 0; i < 4; i++) send(0, 32'd1);
    idle(0);
    wait_out(0);

    @(posedge clk);
    #1 out_ready[0] = 1'b0;
    send(0, 32'd1); send(0, 32'd2); send(0, 32'd3); send(0, 32'd4);
    idle(0);
    wait_valid(0);
    clear[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0;
    chk("clear in OUT {in_ready,out_valid,out_ovf,out_sum}", {in_ready[0], out_valid[0], out_ovf[0], out_sum[0]}, {32'd0, 1'b1, 1'b0, 1'b0, 32'd0});

    send(0, 32'd9); send(0, 32'd9); send(0, 32'd9); send(0, 32'd9);
    idle(0);
    wait_valid(0);
    #2 rst_n = 1'b0;
    #1 chk("async reset in OUT {in_ready,out_valid,out_ovf,out_sum}", {in_ready[0], out_valid[0], out_ovf[0], out_sum[0]}, 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    out_ready[0] = 1'b1;
    send(0, 32'd5); send(0, 32'd5);
    idle(0);
    #2 rst_n = 1'b0;
    #1 chk("async reset mid-group {in_ready,out_valid,out_sum}", {in_ready[0], out_valid[0], out_sum[0]}, 64'd0);
    model_reset();
    #1 rst_n = 1'b1;
    exp_q[0].push_back({1'b0, 32'd28});
    for (int i = 0; i < 4; i++) send(0, 32'd7);
    idle(0);
    wait_out(0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
